jtag_tap_ctrl: RTL and testbench

IEEE 1149.1-style TAP controller that sequences the team's serial DR chains, including the IDCODE chain and user chains. It runs the 16-state TAP FSM from TMS and holds an instruction register. Per state, it drives the chains' SEL_CHAIN and LOAD_CHAIN inputs and muxes their SO outputs onto TDO. It sits between the JTAG pins and NUM_CHAINS external DR chains.

---
 rtl/jtag_pkg.sv | 28 ++
 rtl/jtag_tap_fsm.sv | 48 ++++
 rtl/jtag_tap_ctrl.sv | 134 +++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, Capture-IR pattern and default IDCODE instruction.
package jtag_pkg;

    localparam int unsigned TAP_STATE_W     = 4;
    localparam int unsigned IR_CAPTURE_PAT  = 32'h0000_0001;
    localparam int unsigned IDCODE_INST_DEF = 0;

    // IEEE 1149.1 reference encoding, so STATE reads like the standard's tables
    typedef enum logic [TAP_STATE_W-1:0] {
        TAP_EXIT2_DR   = 4'h0,
        TAP_EXIT1_DR   = 4'h1,
        TAP_SHIFT_DR   = 4'h2,
        TAP_PAUSE_DR   = 4'h3,
        TAP_SELECT_IR  = 4'h4,
        TAP_UPDATE_DR  = 4'h5,
        TAP_CAPTURE_DR = 4'h6,
        TAP_SELECT_DR  = 4'h7,
        TAP_EXIT2_IR   = 4'h8,
        TAP_EXIT1_IR   = 4'h9,
        TAP_SHIFT_IR   = 4'hA,
        TAP_PAUSE_IR   = 4'hB,
        TAP_RUN_IDLE   = 4'hC,
        TAP_UPDATE_IR  = 4'hD,
        TAP_CAPTURE_IR = 4'hE,
        TAP_RESET      = 4'hF
    } tap_state_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine; exposes the registered state and the state it moves to next.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tms_i,
    output tap_state_t state_o,
    output tap_state_t state_next_o
);

    tap_state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TAP_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_RESET:      state_d = tms_i ? TAP_RESET     : TAP_RUN_IDLE;
            TAP_RUN_IDLE:   state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_IDLE;
            TAP_SELECT_DR:  state_d = tms_i ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: state_d = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   state_d = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   state_d = tms_i ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   state_d = tms_i ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   state_d = tms_i ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_IDLE;
            TAP_SELECT_IR:  state_d = tms_i ? TAP_RESET     : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: state_d = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   state_d = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   state_d = tms_i ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   state_d = tms_i ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   state_d = tms_i ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_IDLE;
            default:        state_d = TAP_RESET;
        endcase
    end

    assign state_o      = state_q;
    assign state_next_o = state_d;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller: IR, chain decode, optional bypass register and TDO mux.
// Optional bypass register enabled by defining JTAG_TAP_BYPASS_EN.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned NUM_CHAINS  = 4,
    parameter int unsigned IR_WIDTH    = 4,
    parameter int unsigned IDCODE_INST = IDCODE_INST_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tms_i,
    input  logic                  tdi_i,
    output logic                  tdo_o,
    output logic                  tdo_en_o,
    output logic                  chain_si_o,
    input  logic [NUM_CHAINS-1:0] chain_so_i,
    output logic [NUM_CHAINS-1:0] sel_chain_o,
    output logic                  load_chain_o,
    output logic                  update_dr_o,
    output logic [IR_WIDTH-1:0]   ir_out_o,
    output logic [TAP_STATE_W-1:0] state_o
);

    localparam int unsigned SEL_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

    tap_state_t          state, state_next;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic                chain_hit;
    logic [SEL_W-1:0]    sel_idx;
    logic                bypass_bit;

    jtag_tap_fsm u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .tms_i        (tms_i),
        .state_o      (state),
        .state_next_o (state_next)
    );

    assign state_o    = state;
    assign chain_si_o = tdi_i;
    assign ir_out_o   = ir_q;
    assign chain_hit  = 32'(ir_q) < NUM_CHAINS;
    assign sel_idx    = SEL_W'(ir_q);

    // IR returns to IDCODE on the edge that enters Test-Logic-Reset
    always_comb begin
        ir_d    = ir_q;
        ir_sr_d = ir_sr_q;
        if (state == TAP_CAPTURE_IR) begin
            ir_sr_d = IR_WIDTH'(IR_CAPTURE_PAT);
        end else if (state == TAP_SHIFT_IR) begin
            ir_sr_d = {tdi_i, ir_sr_q[IR_WIDTH-1:1]};
        end
        if (state == TAP_UPDATE_IR) begin
            ir_d = ir_sr_q;
        end
        if (state_next == TAP_RESET) begin
            ir_d = IR_WIDTH'(IDCODE_INST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q    <= IR_WIDTH'(IDCODE_INST);
            ir_sr_q <= '0;
        end else begin
            ir_q    <= ir_d;
            ir_sr_q <= ir_sr_d;
        end
    end

`ifdef JTAG_TAP_BYPASS_EN
    logic bypass_q, bypass_d;

    always_comb begin
        bypass_d = bypass_q;
        if (state == TAP_CAPTURE_DR) begin
            bypass_d = 1'b0;
        end else if (state == TAP_SHIFT_DR) begin
            bypass_d = tdi_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= bypass_d;
        end
    end

    assign bypass_bit = bypass_q;
`else
    assign bypass_bit = 1'b0;
`endif

    // Strobes and TDO decode straight from the registered state
    always_comb begin
        tdo_o        = 1'b0;
        tdo_en_o     = 1'b0;
        sel_chain_o  = '0;
        load_chain_o = 1'b0;
        update_dr_o  = 1'b0;
        case (state)
            TAP_CAPTURE_DR: begin
                load_chain_o = 1'b1;
                if (chain_hit) begin
                    sel_chain_o = NUM_CHAINS'(1) << sel_idx;
                end
            end
            TAP_SHIFT_DR: begin
                tdo_en_o = 1'b1;
                if (chain_hit) begin
                    sel_chain_o = NUM_CHAINS'(1) << sel_idx;
                    tdo_o       = chain_so_i[sel_idx];
                end else begin
                    tdo_o = bypass_bit;
                end
            end
            TAP_SHIFT_IR: begin
                tdo_en_o = 1'b1;
                tdo_o    = ir_sr_q[0];
            end
            TAP_UPDATE_DR: begin
                update_dr_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomised bench for jtag_tap_ctrl: reference TAP model feeds a queue, a negedge monitor checks the DUT.
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

    localparam int unsigned NC   = 4;
    localparam int unsigned IRW  = 4;
    localparam int unsigned CLEN = 8;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            tms   = 1'b1;
    logic            tdi   = 1'b0;
    logic            tdo, tdo_en, chain_si, load_chain, update_dr;
    logic [NC-1:0]   chain_so, sel_chain;
    logic [IRW-1:0]  ir_out;
    logic [3:0]      state;

    jtag_tap_ctrl #(.NUM_CHAINS(NC), .IR_WIDTH(IRW), .IDCODE_INST(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tms_i        (tms),
        .tdi_i        (tdi),
        .tdo_o        (tdo),
        .tdo_en_o     (tdo_en),
        .chain_si_o   (chain_si),
        .chain_so_i   (chain_so),
        .sel_chain_o  (sel_chain),
        .load_chain_o (load_chain),
        .update_dr_o  (update_dr),
        .ir_out_o     (ir_out),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    // External chains: capture on LOAD with SEL, shift toward SO with SEL
    logic [CLEN-1:0] cap [NC];
    logic [CLEN-1:0] env_chain [NC] = '{default: '0};

    always @(posedge clk) begin
        for (int k = 0; k < int'(NC); k++) begin
            if (sel_chain[k]) begin
                env_chain[k] <= load_chain ? cap[k] : {chain_si, env_chain[k][CLEN-1:1]};
            end
        end
    end

    for (genvar g = 0; g < int'(NC); g++) begin : g_so
        assign chain_so[g] = env_chain[g][0];
    end

    typedef struct {
        tap_state_t     st;
        logic [IRW-1:0] ir;
        logic           tdo;
        logic           tdo_en;
        logic           si;
        logic           load;
        logic           upd;
        logic [NC-1:0]  sel;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model state
    tap_state_t      nxt0 [16];
    tap_state_t      nxt1 [16];
    tap_state_t      m_st;
    logic [IRW-1:0]  m_ir, m_irsr;
    logic            m_byp;
    logic [CLEN-1:0] m_chain [NC];

    task automatic arc(input tap_state_t s, input tap_state_t on0, input tap_state_t on1);
        nxt0[int'(s)] = on0;
        nxt1[int'(s)] = on1;
    endtask

    function automatic exp_t predict(input logic tdi_v);
        exp_t e;
        int   k   = int'(m_ir);
        logic hit = (k < int'(NC));
        e.st     = m_st;
        e.ir     = m_ir;
        e.si     = tdi_v;
        e.load   = (m_st == TAP_CAPTURE_DR);
        e.upd    = (m_st == TAP_UPDATE_DR);
        e.tdo_en = (m_st == TAP_SHIFT_DR) || (m_st == TAP_SHIFT_IR);
        e.sel    = '0;
        e.tdo    = 1'b0;
        if (hit && (m_st == TAP_CAPTURE_DR || m_st == TAP_SHIFT_DR)) e.sel[k] = 1'b1;
        if (m_st == TAP_SHIFT_IR) e.tdo = m_irsr[0];
        if (m_st == TAP_SHIFT_DR) begin
            if (hit) e.tdo = m_chain[k][0];
`ifdef JTAG_TAP_BYPASS_EN
            else     e.tdo = m_byp;
`endif
        end
        return e;
    endfunction

    task automatic advance(input logic tms_v, input logic tdi_v);
        int   k   = int'(m_ir);
        logic hit = (k < int'(NC));
        case (m_st)
            TAP_CAPTURE_DR: begin
                if (hit) m_chain[k] = cap[k];
                m_byp = 1'b0;
            end
            TAP_SHIFT_DR: begin
                if (hit) m_chain[k] = {tdi_v, m_chain[k][CLEN-1:1]};
                m_byp = tdi_v;
            end
            TAP_CAPTURE_IR: m_irsr = 4'b0001;
            TAP_SHIFT_IR:   m_irsr = {tdi_v, m_irsr[IRW-1:1]};
            TAP_UPDATE_IR:  m_ir = m_irsr;
            default: ;
        endcase
        m_st = tms_v ? nxt1[int'(m_st)] : nxt0[int'(m_st)];
        if (m_st == TAP_RESET) m_ir = '0;
    endtask

    task automatic step(input logic tms_v, input logic tdi_v);
        @(posedge clk);
        #1;
        tms = tms_v;
        tdi = tdi_v;
        exp_q.push_back(predict(tdi_v));
        advance(tms_v, tdi_v);
    endtask

    task automatic shift_ir(input logic [IRW-1:0] v);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < int'(IRW); i++) step(i == int'(IRW) - 1, v[i]);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] d);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) step(i == n - 1, d[i]);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic walk(input int n);
        repeat (n) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic reset5();
        repeat (5) step(1'b1, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0);
    endtask

    // Asynchronous reset in the middle of a cycle: strobes must drop before any edge
    task automatic reset_now();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        tms   = 1'b1;
        #1;
        chk("rst_state",  32'(state),   32'(TAP_RESET));
        chk("rst_sel",    32'(sel_chain), 32'(0));
        chk("rst_tdo_en", 32'(tdo_en),  32'(0));
        chk("rst_tdo",    32'(tdo),     32'(0));
        chk("rst_ir",     32'(ir_out),  32'(0));
        m_st   = TAP_RESET;
        m_ir   = '0;
        m_irsr = '0;
        m_byp  = 1'b0;
        #1;
        rst_n = 1'b1;
        advance(1'b1, tdi);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state",      32'(state),      32'(e.st));
            chk("ir_out",     32'(ir_out),     32'(e.ir));
            chk("tdo",        32'(tdo),        32'(e.tdo));
            chk("tdo_en",     32'(tdo_en),     32'(e.tdo_en));
            chk("chain_si",   32'(chain_si),   32'(e.si));
            chk("load_chain", 32'(load_chain), 32'(e.load));
            chk("update_dr",  32'(update_dr),  32'(e.upd));
            chk("sel_chain",  32'(sel_chain),  32'(e.sel));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arc(TAP_RESET,      TAP_RUN_IDLE,   TAP_RESET);
        arc(TAP_RUN_IDLE,   TAP_RUN_IDLE,   TAP_SELECT_DR);
        arc(TAP_SELECT_DR,  TAP_CAPTURE_DR, TAP_SELECT_IR);
        arc(TAP_CAPTURE_DR, TAP_SHIFT_DR,   TAP_EXIT1_DR);
        arc(TAP_SHIFT_DR,   TAP_SHIFT_DR,   TAP_EXIT1_DR);
        arc(TAP_EXIT1_DR,   TAP_PAUSE_DR,   TAP_UPDATE_DR);
        arc(TAP_PAUSE_DR,   TAP_PAUSE_DR,   TAP_EXIT2_DR);
        arc(TAP_EXIT2_DR,   TAP_SHIFT_DR,   TAP_UPDATE_DR);
        arc(TAP_UPDATE_DR,  TAP_RUN_IDLE,   TAP_SELECT_DR);
        arc(TAP_SELECT_IR,  TAP_CAPTURE_IR, TAP_RESET);
        arc(TAP_CAPTURE_IR, TAP_SHIFT_IR,   TAP_EXIT1_IR);
        arc(TAP_SHIFT_IR,   TAP_SHIFT_IR,   TAP_EXIT1_IR);
        arc(TAP_EXIT1_IR,   TAP_PAUSE_IR,   TAP_UPDATE_IR);
        arc(TAP_PAUSE_IR,   TAP_PAUSE_IR,   TAP_EXIT2_IR);
        arc(TAP_EXIT2_IR,   TAP_SHIFT_IR,   TAP_UPDATE_IR);
        arc(TAP_UPDATE_IR,  TAP_RUN_IDLE,   TAP_SELECT_DR);

        cap[0] = 8'ha5;
        for (int k = 1; k < int'(NC); k++) cap[k] = 8'($urandom);
        for (int k = 0; k < int'(NC); k++) m_chain[k] = '0;
        m_st   = TAP_RESET;
        m_ir   = '0;
        m_irsr = '0;
        m_byp  = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("init_state",  32'(state),      32'(TAP_RESET));
        chk("init_ir",     32'(ir_out),     32'(0));
        chk("init_tdo",    32'(tdo),        32'(0));
        chk("init_tdo_en", 32'(tdo_en),     32'(0));
        chk("init_sel",    32'(sel_chain),  32'(0));
        chk("init_load",   32'(load_chain), 32'(0));
        chk("init_upd",    32'(update_dr),  32'(0));
        rst_n = 1'b1;

        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        shift_ir(4'd3);
        reset5();
        shift_dr(8, 32'h0);
        shift_ir(4'b0010);
        shift_dr(8, $urandom);
        shift_ir(4'hF);
        shift_dr(4, 32'b1011);

        shift_ir(4'd1);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b0);
        reset_now();
        step(1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            shift_ir(4'($urandom_range(0, 15)));
            shift_dr(int'($urandom_range(1, 12)), $urandom);
            walk(int'($urandom_range(4, 16)));
            reset5();
        end

        repeat (3) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
